// File: rtl/vdp_vram_arbiter.sv
// Four-way VRAM port arbiter (screen > sprite > command > cpu) with one access in flight.
// Optional CPU starvation boost: define VDP_ARB_CPU_BOOST_EN.
module vdp_vram_arbiter #(
  parameter int READ_TIMEOUT = 16,
  parameter int CPU_MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        initial_busy,
  input  logic        s_valid,
  input  logic        s_write,
  input  logic [16:0] s_address,
  input  logic [7:0]  s_wdata,
  output logic        s_ready,
  output logic [31:0] s_rdata,
  output logic        s_rdata_en,
  input  logic        p_valid,
  input  logic        p_write,
  input  logic [16:0] p_address,
  input  logic [7:0]  p_wdata,
  output logic        p_ready,
  output logic [31:0] p_rdata,
  output logic        p_rdata_en,
  input  logic        c_valid,
  input  logic        c_write,
  input  logic [16:0] c_address,
  input  logic [7:0]  c_wdata,
  output logic        c_ready,
  output logic [31:0] c_rdata,
  output logic        c_rdata_en,
  input  logic        u_valid,
  input  logic        u_write,
  input  logic [16:0] u_address,
  input  logic [7:0]  u_wdata,
  output logic        u_ready,
  output logic [31:0] u_rdata,
  output logic        u_rdata_en,
  output logic [16:0] vram_address,
  output logic        vram_write,
  output logic        vram_valid,
  output logic [7:0]  vram_wdata,
  input  logic [31:0] vram_rdata,
  input  logic        vram_rdata_en,
  output logic        timeout_err
);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_READ_WAIT = 1'b1;
  localparam int         TW           = $clog2(READ_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(READ_TIMEOUT - 1);

  // Requester index: 0 = screen, 1 = sprite, 2 = command, 3 = cpu
  logic [3:0]  req_valid;
  logic [3:0]  req_write;
  logic [16:0] req_address [4];
  logic [7:0]  req_wdata   [4];

  assign req_valid      = {u_valid, c_valid, p_valid, s_valid};
  assign req_write      = {u_write, c_write, p_write, s_write};
  assign req_address[0] = s_address;
  assign req_address[1] = p_address;
  assign req_address[2] = c_address;
  assign req_address[3] = u_address;
  assign req_wdata[0]   = s_wdata;
  assign req_wdata[1]   = p_wdata;
  assign req_wdata[2]   = c_wdata;
  assign req_wdata[3]   = u_wdata;

  logic [0:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [3:0]    ready_q, ready_d;
  logic [3:0]    rdata_en_q, rdata_en_d;
  logic [31:0]   rdata_q [4];
  logic [31:0]   rdata_d [4];
  logic [16:0]   vram_address_q, vram_address_d;
  logic          vram_write_q, vram_write_d;
  logic          vram_valid_q, vram_valid_d;
  logic [7:0]    vram_wdata_q, vram_wdata_d;
  logic          timeout_err_q, timeout_err_d;

  logic       boost;
  logic       grant;
  logic [1:0] win;

`ifdef VDP_ARB_CPU_BOOST_EN
  localparam logic [6:0] BOOST_AT = 7'(CPU_MAX_WAIT);
  logic [6:0] boost_cnt_q, boost_cnt_d;

  assign boost = (boost_cnt_q >= BOOST_AT);

  always_comb begin
    boost_cnt_d = boost_cnt_q;
    if (!u_valid || (grant && (win == 2'd3))) begin
      boost_cnt_d = 7'd0;
    end else if (boost_cnt_q != 7'h7F) begin
      boost_cnt_d = boost_cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      boost_cnt_q <= 7'd0;
    end else begin
      boost_cnt_q <= boost_cnt_d;
    end
  end
`else
  // Boost disabled: the parameter only keeps the instance interface stable.
  assign boost = (CPU_MAX_WAIT < 0);
`endif

  // The cycle after an issue (vram_valid high) is never an arbitration slot.
  always_comb begin
    grant = 1'b0;
    win   = 2'd0;
    if ((state_q == ST_IDLE) && !initial_busy && !vram_valid_q && (|req_valid)) begin
      grant = 1'b1;
      if (boost && req_valid[3]) win = 2'd3;
      else if (req_valid[0])     win = 2'd0;
      else if (req_valid[1])     win = 2'd1;
      else if (req_valid[2])     win = 2'd2;
      else                       win = 2'd3;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wait_d         = wait_q;
    ready_d        = 4'd0;
    rdata_en_d     = 4'd0;
    rdata_d        = rdata_q;
    vram_address_d = vram_address_q;
    vram_write_d   = vram_write_q;
    vram_valid_d   = 1'b0;
    vram_wdata_d   = vram_wdata_q;
    timeout_err_d  = 1'b0;
    if (grant) begin
      ready_d[win]   = 1'b1;
      vram_valid_d   = 1'b1;
      vram_address_d = req_address[win];
      vram_write_d   = req_write[win];
      vram_wdata_d   = req_write[win] ? req_wdata[win] : 8'd0;
      if (!req_write[win]) begin
        state_d = ST_READ_WAIT;
        owner_d = win;
        wait_d  = '0;
      end
    end else if (state_q == ST_READ_WAIT) begin
      if (vram_rdata_en) begin
        rdata_d[owner_q]    = vram_rdata;
        rdata_en_d[owner_q] = 1'b1;
        state_d             = ST_IDLE;
      end else if (wait_q == WAIT_LAST) begin
        rdata_d[owner_q]    = 32'hFFFF_FFFF;
        rdata_en_d[owner_q] = 1'b1;
        timeout_err_d       = 1'b1;
        state_d             = ST_IDLE;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= 2'd0;
      wait_q         <= '0;
      ready_q        <= 4'd0;
      rdata_en_q     <= 4'd0;
      for (int i = 0; i < 4; i++) rdata_q[i] <= 32'd0;
      vram_address_q <= 17'd0;
      vram_write_q   <= 1'b0;
      vram_valid_q   <= 1'b0;
      vram_wdata_q   <= 8'd0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      wait_q         <= wait_d;
      ready_q        <= ready_d;
      rdata_en_q     <= rdata_en_d;
      rdata_q        <= rdata_d;
      vram_address_q <= vram_address_d;
      vram_write_q   <= vram_write_d;
      vram_valid_q   <= vram_valid_d;
      vram_wdata_q   <= vram_wdata_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign s_ready      = ready_q[0];
  assign p_ready      = ready_q[1];
  assign c_ready      = ready_q[2];
  assign u_ready      = ready_q[3];
  assign s_rdata_en   = rdata_en_q[0];
  assign p_rdata_en   = rdata_en_q[1];
  assign c_rdata_en   = rdata_en_q[2];
  assign u_rdata_en   = rdata_en_q[3];
  assign s_rdata      = rdata_q[0];
  assign p_rdata      = rdata_q[1];
  assign c_rdata      = rdata_q[2];
  assign u_rdata      = rdata_q[3];
  assign vram_address = vram_address_q;
  assign vram_write   = vram_write_q;
  assign vram_valid   = vram_valid_q;
  assign vram_wdata   = vram_wdata_q;
  assign timeout_err  = timeout_err_q;

endmodule
